seq_player: RTL and testbench
=============================

// Module: seq_player
// PURPOSE
//  Plays a stored 64-bit sequence back to the player, one 4-bit symbol at a time on the LEDs.
//  Consumer side of the sequence registers: the user-sequence register captures what the player typed;
//  seq_player reads the reference sequence and shows the first round+1 symbols.
//  Shows symbols in order, timed by an external tick, with a blank gap between symbols.
//  Pulses done when playback ends.
// PARAMETERS
//  P_SEQ   64  sequence width in bits (P_SEQ/P_SYM symbols, 16 at defaults)
//  P_SYM   4   symbol width in bits (one LED per bit)
//  P_ON    2   ticks each symbol stays lit (>=1)
//  P_OFF   1   ticks of blank gap between symbols (>=1)
// PORTS
//  clk     in   1      clock
//  R       in   1      reset: synchronous, active-high
//  start   in   1      playback request, sampled only in IDLE
//  seq     in   P_SEQ  sequence; symbol 0 = seq[P_SEQ-1 -: P_SYM] (MSB nibble first)
//  round   in   4      index of last symbol to play (plays round+1 symbols, 1..16)
//  tick    in   1      1-cycle timebase pulse
//  leds    out  P_SYM  current symbol, 0 when not in SHOW
//  busy    out  1      high in SHOW/GAP/DONE
//  done    out  1      1-cycle pulse when playback completes
// BEHAVIOUR
//  - All outputs are registered. On R=1 at a clk edge: state=IDLE, leds=0, busy=0, done=0, counters=0.
//  - On start in IDLE, seq and round are latched. Later changes to seq/round do not affect playback.
//  - FSM states: IDLE, SHOW, GAP, DONE.
//  - IDLE->SHOW on start. sym_idx=0, tick_cnt=0. At edge t+1: busy=1, leds=symbol 0.
//  - SHOW: tick_cnt++ on each tick. On the tick where tick_cnt==P_ON-1:
//      - if sym_idx==round_l -> DONE
//      - else -> GAP, leds=0, tick_cnt=0
//  - GAP: on the tick where tick_cnt==P_OFF-1 -> SHOW, sym_idx++, leds=next symbol, tick_cnt=0.
//  - DONE: lasts 1 cycle with done=1, leds=0, busy=1. Then IDLE (busy=0, done=0).
//  - A tick in the same cycle as the accepted start is ignored. Counting starts at the next tick.
//  - start while busy is ignored and does not queue.
//  - Cycles without tick hold the state. A symbol is lit for exactly P_ON ticks.
//  - round=0: one symbol is shown, then DONE, with no GAP.
//  - round=15: all 16 symbols play. sym_idx is 4 bits and never wraps.
//  - R mid-playback: IDLE on the next edge, leds=0, no done pulse.
//  - R takes priority over start in the same cycle.
// CONFIGURATION
//  SEQ_PLAYER_ABORT_EN defined:
//    - adds input abort (1 bit).
//    - abort=1 in SHOW or GAP: next edge -> IDLE, leds=0, busy=0, done not pulsed.
//    - abort in IDLE or DONE has no effect. R outranks abort.
//  SEQ_PLAYER_ABORT_EN undefined: no abort port; playback always runs to DONE.
// STRUCTURE
//  - Package seq_pkg holds: P_SEQ, P_SYM, derived symbol count, FSM state encoding (2-bit enum).
//    The same constants are shared with the user-sequence register and the comparator.
//  - Sub-module tick_counter (clk, R, clr, tick, limit -> hit):
//      counts ticks up to limit-1; instantiated once and reused for the SHOW and GAP durations.
//  - Symbol select is a left-shift of the latched sequence by P_SYM per symbol, top P_SYM bits to leds.
// TESTING
//  1. R high 2 cycles, then low -> leds=0, busy=0, done=0; start held 1 during R -> stays IDLE.
//  2. seq=64'h1248_0000_0000_0000, round=3, tick every 4 clk -> leds 1,0,2,0,4,0,8 (2 ticks lit, 1 gap);
//     done pulses exactly once; busy falls one cycle after done.
//  3. round=0, seq=64'hF000_0000_0000_0000 -> leds=F for 2 ticks, then done, no GAP.
//  4. start, then seq changed to 0 and start re-pulsed mid-playback -> original symbols play;
//     no second playback.
//  5. R asserted during symbol 2 of round=5 -> next cycle leds=0, busy=0; done never pulses.
//  6. [SEQ_PLAYER_ABORT_EN] abort in GAP after symbol 1 -> IDLE next cycle, no done;
//     a new start then replays from symbol 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and FSM encoding for the sequence player, user-sequence register and comparator.
package seq_pkg;

    localparam int P_SEQ   = 64;
    localparam int P_SYM   = 4;
    localparam int P_NSYM  = P_SEQ / P_SYM;
    localparam int P_IDX_W = $clog2(P_NSYM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    function automatic logic [P_SYM-1:0] top_sym(input logic [P_SEQ-1:0] s);
        return s[P_SEQ-1 -: P_SYM];
    endfunction

endpackage

// File: rtl/seq_player_tick_counter.sv
// Tick counter: hit fires on the tick that completes 'limit' ticks, then self-clears.
module tick_counter (
    input  logic       clk,
    input  logic       R,
    input  logic       clr,
    input  logic       tick,
    input  logic [7:0] limit,
    output logic       hit
);

    logic [7:0] cnt;

    assign hit = tick && (cnt == limit - 8'd1);

    always_ff @(posedge clk) begin
        if (R || clr) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= hit ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/seq_player.sv
// Sequence player: shows latched symbols MSB nibble first on leds, tick-timed with blank gaps.
// Optional macro SEQ_PLAYER_ABORT_EN adds an abort input that cancels playback from SHOW/GAP.
//
// state | meaning
// IDLE  | waiting for start, leds dark
// SHOW  | current symbol lit for P_ON ticks
// GAP   | blank for P_OFF ticks before next symbol
// DONE  | one-cycle done pulse, then back to IDLE
module seq_player
    import seq_pkg::*;
#(
    parameter int P_ON  = 2,
    parameter int P_OFF = 1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [P_SEQ-1:0] seq,
    input  logic [3:0]       round,
    input  logic             tick,
`ifdef SEQ_PLAYER_ABORT_EN
    input  logic             abort,
`endif
    output logic [P_SYM-1:0] leds,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] ON_L  = 8'(P_ON);
    localparam logic [7:0] OFF_L = 8'(P_OFF);

    seq_state_e       state, state_nx;
    logic [3:0]       sym_idx, sym_nx;
    logic [3:0]       round_l, round_nx;
    logic [P_SEQ-1:0] seq_l, seq_nx, shifted;
    logic [P_SYM-1:0] leds_nx;
    logic             busy_nx, done_nx;
    logic             clr, hit, abort_act;
    logic [7:0]       limit;

`ifdef SEQ_PLAYER_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign limit   = (state == SHOW) ? ON_L : OFF_L;
    assign shifted = seq_l << P_SYM;

    tick_counter u_tick_counter (
        .clk   (clk),
        .R     (R),
        .clr   (clr),
        .tick  (tick),
        .limit (limit),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            state   <= IDLE;
            sym_idx <= 4'd0;
            round_l <= 4'd0;
            seq_l   <= '0;
            leds    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            sym_idx <= sym_nx;
            round_l <= round_nx;
            seq_l   <= seq_nx;
            leds    <= leds_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sym_nx   = sym_idx;
        round_nx = round_l;
        seq_nx   = seq_l;
        leds_nx  = leds;
        busy_nx  = busy;
        done_nx  = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                // Counter is held clear here, so a tick alongside start is ignored.
                clr     = 1'b1;
                leds_nx = '0;
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = SHOW;
                    seq_nx   = seq;
                    round_nx = round;
                    sym_nx   = 4'd0;
                    leds_nx  = top_sym(seq);
                    busy_nx  = 1'b1;
                end
            end
            SHOW: begin
                if (abort_act) begin
                    state_nx = IDLE;
                    leds_nx  = '0;
                    busy_nx  = 1'b0;
                end else if (hit) begin
                    leds_nx = '0;
                    if (sym_idx == round_l) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                if (abort_act) begin
                    state_nx = IDLE;
                    leds_nx  = '0;
                    busy_nx  = 1'b0;
                end else if (hit) begin
                    state_nx = SHOW;
                    sym_nx   = 4'(sym_idx + 4'd1);
                    seq_nx   = shifted;
                    leds_nx  = top_sym(shifted);
                end
            end
            DONE: begin
                clr      = 1'b1;
                state_nx = IDLE;
                leds_nx  = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player; abort scenario compiled in when SEQ_PLAYER_ABORT_EN is defined.
module tb_seq_player;

    logic        clk = 1'b0;
    logic        R, start, tick;
    logic [63:0] seq;
    logic [3:0]  round;
    logic [3:0]  leds;
    logic        busy, done;
`ifdef SEQ_PLAYER_ABORT_EN
    logic        abort;
`endif

    int vec  = 0;
    int errs = 0;

    logic [3:0] lit_q[$];
    int         lit_t[$];
    int         gap_t[$];
    int         done_cnt, busy_rise, bad_fall;

    always #5 clk = ~clk;

    seq_player dut (
        .clk   (clk),
        .R     (R),
        .start (start),
        .seq   (seq),
        .round (round),
        .tick  (tick),
`ifdef SEQ_PLAYER_ABORT_EN
        .abort (abort),
`endif
        .leds  (leds),
        .busy  (busy),
        .done  (done)
    );

    // Runs one playback and splits the output trace into lit / gap runs with their tick counts.
    task automatic run_play(input logic [63:0] s, input logic [3:0] r, input int period,
                            input int ncyc, input int mid);
        logic [5:0] key, pkey;
        int         tcnt;
        logic       pbusy, pdone;
        lit_q.delete(); lit_t.delete(); gap_t.delete();
        done_cnt = 0; busy_rise = 0; bad_fall = 0;
        @(negedge clk);
        seq = s; round = r; start = 1'b1; tick = 1'b1;
        pkey = 6'd0; tcnt = 0; pbusy = 1'b0; pdone = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            tick  = ((c % period) == period - 1);
            if (c == mid) begin
                seq   = 64'd0;
                start = 1'b1;
            end
            key = {busy, done, leds};
            if (key !== pkey) begin
                if (pkey[3:0] != 4'd0) begin
                    lit_q.push_back(pkey[3:0]);
                    lit_t.push_back(tcnt);
                end else if (pkey[5] && !pkey[4]) begin
                    gap_t.push_back(tcnt);
                end
                tcnt = 0;
            end
            if (pbusy === 1'b1 && busy === 1'b0 && pdone !== 1'b1) bad_fall++;
            if (pdone === 1'b1 && busy !== 1'b0) bad_fall++;
            if (busy === 1'b1 && pbusy === 1'b0) busy_rise++;
            if (done === 1'b1) done_cnt++;
            if (tick) tcnt++;
            pkey = key; pbusy = busy; pdone = done;
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; start = 1'b1; tick = 1'b0; seq = 64'hFFFF_FFFF_FFFF_FFFF; round = 4'd3;
`ifdef SEQ_PLAYER_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++;
            if ({leds, busy, done} !== 6'b0) begin
                errs++;
                $display("FAIL reset_cyc%0d got leds=%h busy=%b done=%b want 0/0/0", i, leds, busy, done);
            end
        end
        R = 1'b0; start = 1'b0;
        @(negedge clk);
        vec++;
        if ({leds, busy, done} !== 6'b0) begin
            errs++;
            $display("FAIL reset_release got leds=%h busy=%b done=%b want 0/0/0", leds, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_sym;
        logic [3:0]  got;
        exp_sym = 16'h1248;
        run_play(64'h1248_0000_0000_0000, 4'd3, 4, 80, -1);
        vec++;
        if (lit_q.size() !== 4) begin
            errs++; $display("FAIL basic_nsym got %0d want 4", lit_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < lit_q.size()) ? lit_q[i] : 4'hx;
            vec++;
            if (got !== exp_sym[15-4*i -: 4]) begin
                errs++; $display("FAIL basic_sym%0d got %h want %h", i, got, exp_sym[15-4*i -: 4]);
            end
            vec++;
            if (i < lit_t.size() && lit_t[i] !== 2) begin
                errs++; $display("FAIL basic_lit_ticks%0d got %0d want 2", i, lit_t[i]);
            end
        end
        vec++;
        if (gap_t.size() !== 3) begin
            errs++; $display("FAIL basic_ngap got %0d want 3", gap_t.size());
        end
        for (int i = 0; i < gap_t.size(); i++) begin
            vec++;
            if (gap_t[i] !== 1) begin
                errs++; $display("FAIL basic_gap_ticks%0d got %0d want 1", i, gap_t[i]);
            end
        end
        vec++;
        if (done_cnt !== 1) begin
            errs++; $display("FAIL basic_done got %0d pulses want 1", done_cnt);
        end
        vec++;
        if (bad_fall !== 0) begin
            errs++; $display("FAIL basic_busy_fall got %0d bad cycles want 0", bad_fall);
        end
    endtask

    task automatic test_round0();
        run_play(64'hF000_0000_0000_0000, 4'd0, 4, 40, -1);
        vec++;
        if (lit_q.size() !== 1 || lit_q[0] !== 4'hF) begin
            errs++; $display("FAIL round0_sym got n=%0d first=%h want n=1 F", lit_q.size(), lit_q[0]);
        end
        vec++;
        if (lit_t.size() < 1 || lit_t[0] !== 2) begin
            errs++; $display("FAIL round0_ticks got %0d want 2", lit_t.size() ? lit_t[0] : -1);
        end
        vec++;
        if (gap_t.size() !== 0) begin
            errs++; $display("FAIL round0_gap got %0d gaps want 0", gap_t.size());
        end
        vec++;
        if (done_cnt !== 1 || bad_fall !== 0) begin
            errs++; $display("FAIL round0_done got done=%0d badfall=%0d want 1/0", done_cnt, bad_fall);
        end
    endtask

    task automatic test_full16();
        logic [63:0] exp_seq;
        logic [3:0]  got;
        exp_seq = 64'h1234_5678_9ABC_DEF1;
        run_play(64'h1234_5678_9ABC_DEF1, 4'd15, 1, 70, -1);
        vec++;
        if (lit_q.size() !== 16) begin
            errs++; $display("FAIL full16_nsym got %0d want 16", lit_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < lit_q.size()) ? lit_q[i] : 4'hx;
            vec++;
            if (got !== exp_seq[63-4*i -: 4]) begin
                errs++; $display("FAIL full16_sym%0d got %h want %h", i, got, exp_seq[63-4*i -: 4]);
            end
        end
        vec++;
        if (gap_t.size() !== 15 || done_cnt !== 1) begin
            errs++; $display("FAIL full16_gap_done got gaps=%0d done=%0d want 15/1", gap_t.size(), done_cnt);
        end
    endtask

    task automatic test_ignore_restart();
        logic [11:0] exp_sym;
        logic [3:0]  got;
        exp_sym = 12'hA5C;
        run_play(64'hA5C0_0000_0000_0000, 4'd2, 4, 90, 10);
        vec++;
        if (lit_q.size() !== 3) begin
            errs++; $display("FAIL restart_nsym got %0d want 3", lit_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < lit_q.size()) ? lit_q[i] : 4'hx;
            vec++;
            if (got !== exp_sym[11-4*i -: 4]) begin
                errs++; $display("FAIL restart_sym%0d got %h want %h", i, got, exp_sym[11-4*i -: 4]);
            end
        end
        vec++;
        if (busy_rise !== 1 || done_cnt !== 1) begin
            errs++; $display("FAIL restart_once got plays=%0d done=%0d want 1/1", busy_rise, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int found, dn, bz;
        found = 0; dn = 0; bz = 0;
        @(negedge clk);
        seq = 64'h1234_5600_0000_0000; round = 4'd5; start = 1'b1; tick = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            tick  = ((c % 4) == 3);
            if (leds === 4'h3) begin
                found = 1;
                break;
            end
        end
        vec++;
        if (found !== 1) begin
            errs++; $display("FAIL rstmid_reach got found=%0d want 1", found);
        end
        R = 1'b1; tick = 1'b0;
        @(negedge clk);
        R = 1'b0;
        vec++;
        if ({leds, busy, done} !== 6'b0) begin
            errs++; $display("FAIL rstmid_idle got leds=%h busy=%b done=%b want 0/0/0", leds, busy, done);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            tick = ((c % 4) == 3);
            if (done === 1'b1) dn++;
            if (busy === 1'b1) bz++;
        end
        tick = 1'b0;
        vec++;
        if (dn !== 0 || bz !== 0) begin
            errs++; $display("FAIL rstmid_quiet got done=%0d busy=%0d cycles want 0/0", dn, bz);
        end
    endtask

`ifdef SEQ_PLAYER_ABORT_EN
    task automatic test_abort();
        int phase, dn, bz;
        phase = 0; dn = 0; bz = 0;
        @(negedge clk);
        seq = 64'h1234_0000_0000_0000; round = 4'd3; start = 1'b1; tick = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            tick  = ((c % 4) == 3);
            if (phase == 0 && leds === 4'h2) phase = 1;
            else if (phase == 1 && leds === 4'h0 && busy === 1'b1) begin
                phase = 2;
                break;
            end
        end
        vec++;
        if (phase !== 2) begin
            errs++; $display("FAIL abort_reach_gap got phase=%0d want 2", phase);
        end
        abort = 1'b1; tick = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        vec++;
        if ({leds, busy, done} !== 6'b0) begin
            errs++; $display("FAIL abort_idle got leds=%h busy=%b done=%b want 0/0/0", leds, busy, done);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            tick = ((c % 4) == 3);
            if (done === 1'b1) dn++;
            if (busy === 1'b1) bz++;
        end
        vec++;
        if (dn !== 0 || bz !== 0) begin
            errs++; $display("FAIL abort_quiet got done=%0d busy=%0d cycles want 0/0", dn, bz);
        end
        tick = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vec++;
        if (leds !== 4'h1 || busy !== 1'b1) begin
            errs++; $display("FAIL abort_replay got leds=%h busy=%b want 1/1", leds, busy);
        end
        run_play(64'h1234_0000_0000_0000, 4'd0, 4, 1, -1);
        repeat (20) begin
            @(negedge clk);
            tick = ~tick;
        end
        tick = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round0();
        test_full16();
        test_ignore_restart();
        test_reset_mid();
`ifdef SEQ_PLAYER_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
